// File: rtl/in_port_arbiter.sv
// -----------------------------------------------------------------------------
// in_port_arbiter
//
// Purpose:
//   Sits between two byte requesters and a small processor core that reads
//   input ports. The requesters are a keyboard and a clock/timer source.
//   One pending byte is accepted at a time. When both requesters are pending,
//   arbitration is round-robin. The accepted byte is held and an interrupt is
//   raised. The transaction completes when the core reads DATA_PORT after
//   acknowledging the interrupt. If the core does not finish within
//   TIMEOUT_CYCLES, the byte is discarded. In either case the winning
//   requester receives a one-cycle grant.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   kbd_req        keyboard byte pending (held until kbd_grant)
//   kbd_data[7:0]  keyboard byte
//   kbd_grant      one-cycle pulse: keyboard byte consumed/discarded
//   rtc_req        timer byte pending (held until rtc_grant)
//   rtc_data[7:0]  timer byte
//   rtc_grant      one-cycle pulse: timer byte consumed/discarded
//   interrupt      interrupt request to the core (high while in IRQ)
//   interrupt_ack  core acknowledge
//   read_strobe    core input-read qualifier
//   port_id[7:0]   core port address
//   in_port[7:0]   read data returned to the core (combinational)
//   busy           high whenever not IDLE
//   timeout_err    one-cycle pulse when a transaction is abandoned
// -----------------------------------------------------------------------------
module in_port_arbiter #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] DATA_PORT      = 8'h00,
    parameter logic [7:0] SRC_PORT       = 8'h03
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbd_req,
    input  logic [7:0] kbd_data,
    output logic       kbd_grant,
    input  logic       rtc_req,
    input  logic [7:0] rtc_data,
    output logic       rtc_grant,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic       read_strobe,
    input  logic [7:0] port_id,
    output logic [7:0] in_port,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Source codes: 0 = keyboard, 1 = timer.
    localparam logic SRC_KBD = 1'b0;
    localparam logic SRC_RTC = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IRQ       = 2'd1,
        WAIT_READ = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t           state_reg,     state_next;
    logic [7:0]       hold_data_reg, hold_data_next;
    logic             hold_src_reg,  hold_src_next;
    logic             last_src_reg,  last_src_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    // Remembers that the current RELEASE was reached by timeout, so that
    // timeout_err can pulse together with the grant.
    logic             timed_out_reg, timed_out_next;

    logic             pick_rtc;
    logic             cnt_expired;
    logic             data_read;
    logic [1:0]       grant_vec;

    // The timer wins when it is the only requester. On a tie, it wins only
    // if the keyboard was the last source served.
    assign pick_rtc    = rtc_req && (!kbd_req || (last_src_reg == SRC_KBD));
    assign cnt_expired = (cnt_reg == CNT_LAST);
    assign data_read   = read_strobe && (port_id == DATA_PORT);

    // State register and held transaction context
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            hold_data_reg <= 8'h00;
            hold_src_reg  <= SRC_KBD;
            last_src_reg  <= SRC_RTC;
            cnt_reg       <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_data_reg <= hold_data_next;
            hold_src_reg  <= hold_src_next;
            last_src_reg  <= last_src_next;
            cnt_reg       <= cnt_next;
            timed_out_reg <= timed_out_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        hold_data_next = hold_data_reg;
        hold_src_next  = hold_src_reg;
        last_src_next  = last_src_reg;
        cnt_next       = cnt_reg;
        timed_out_next = timed_out_reg;

        case (state_reg)
            IDLE: begin
                if (kbd_req || rtc_req) begin
                    hold_data_next = pick_rtc ? rtc_data : kbd_data;
                    hold_src_next  = pick_rtc ? SRC_RTC : SRC_KBD;
                    cnt_next       = '0;
                    timed_out_next = 1'b0;
                    state_next     = IRQ;
                end
            end

            IRQ: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // An acknowledge is not a completion. The timeout takes priority here.
                if (cnt_expired) begin
                    timed_out_next = 1'b1;
                    state_next     = RELEASE;
                end else if (interrupt_ack) begin
                    state_next = WAIT_READ;
                end
            end

            WAIT_READ: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // A data read on the expiry cycle still counts as a completion.
                if (data_read) begin
                    state_next = RELEASE;
                end else if (cnt_expired) begin
                    timed_out_next = 1'b1;
                    state_next     = RELEASE;
                end
            end

            RELEASE: begin
                last_src_next = hold_src_reg;
                state_next    = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One grant line per source. Each line is active in RELEASE when the
    // held source code matches that line.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_vec[gi] = (state_reg == RELEASE) && (hold_src_reg == 1'(gi));
        end
    endgenerate

    assign kbd_grant   = grant_vec[0];
    assign rtc_grant   = grant_vec[1];
    assign interrupt   = (state_reg == IRQ);
    assign busy        = (state_reg != IDLE);
    assign timeout_err = (state_reg == RELEASE) && timed_out_reg;

    // Read mux for the core. It is decoded only from port_id and is valid in every state.
    always_comb begin
        in_port = 8'h00;
        if (port_id == DATA_PORT) begin
            in_port = hold_data_reg;
        end else if (port_id == SRC_PORT) begin
            in_port = {7'b0, hold_src_reg};
        end
    end

endmodule

// File: tb/tb_in_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_in_port_arbiter
//
// Directed bench for in_port_arbiter, built with TIMEOUT_CYCLES = 16.
// The bench has one task per scenario. Each task compares DUT outputs inline
// against hand-computed values. Inputs are driven 1 time unit after a rising
// edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_in_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       kbd_req = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_grant;
    logic       rtc_req = 1'b0;
    logic [7:0] rtc_data = 8'h00;
    logic       rtc_grant;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] port_id = 8'h02;
    logic [7:0] in_port;
    logic       busy;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    in_port_arbiter #(
        .TIMEOUT_CYCLES(16),
        .DATA_PORT     (8'h00),
        .SRC_PORT      (8'h03)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .kbd_req      (kbd_req),
        .kbd_data     (kbd_data),
        .kbd_grant    (kbd_grant),
        .rtc_req      (rtc_req),
        .rtc_data     (rtc_data),
        .rtc_grant    (rtc_grant),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .read_strobe  (read_strobe),
        .port_id      (port_id),
        .in_port      (in_port),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in IRQ: acks, reads DATA_PORT, captures grants in RELEASE, and
    // ends in IDLE. If drop is set, the granted requester lowers its request.
    task automatic run_txn(input logic drop, output logic [7:0] data_seen,
                           output logic kg, output logic rg, output logic te);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        port_id       = 8'h00;
        read_strobe   = 1'b1;
        #1;
        data_seen = in_port;
        step();
        read_strobe = 1'b0;
        kg = kbd_grant;
        rg = rtc_grant;
        te = timeout_err;
        if (drop && kg) kbd_req = 1'b0;
        if (drop && rg) rtc_req = 1'b0;
        step();
        $display("txn data=%02h kbd_grant=%0b rtc_grant=%0b timeout_err=%0b", data_seen, kg, rg, te);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq: got %0b required 0", interrupt); end
        checks++; if ({kbd_grant, rtc_grant, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %03b required 000", {kbd_grant, rtc_grant, timeout_err}); end
        port_id = 8'h00; #1;
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL reset_hold_data: got %02h required 00", in_port); end
        port_id = 8'h03; #1;
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL reset_hold_src: got %02h required 00", in_port); end
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy: got %0b required 0", busy); end
    endtask

    task automatic test_kbd_basic();
        kbd_data = 8'h57;
        kbd_req  = 1'b1;
        step();
        checks++; if (interrupt !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL kbd_irq: got irq=%0b busy=%0b required 1 1", interrupt, busy); end
        step();
        step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        checks++; if (interrupt !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL kbd_ack: got irq=%0b busy=%0b required 0 1", interrupt, busy); end
        port_id = 8'h00;
        read_strobe = 1'b1;
        #1;
        checks++; if (in_port !== 8'h57) begin failures++; $display("FAIL kbd_data: got %02h required 57", in_port); end
        step();
        read_strobe = 1'b0;
        checks++; if (kbd_grant !== 1'b1 || rtc_grant !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL kbd_grant: got kg=%0b rg=%0b te=%0b required 1 0 0", kbd_grant, rtc_grant, timeout_err); end
        kbd_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || kbd_grant !== 1'b0) begin failures++; $display("FAIL kbd_done: got busy=%0b kg=%0b required 0 0", busy, kbd_grant); end
        $display("txn data=57 kbd_grant=1 rtc_grant=0 timeout_err=0");
    endtask

    task automatic test_round_robin();
        logic [7:0] d;
        logic kg, rg, te;
        reset    = 1'b0;
        kbd_data = 8'hA1;
        rtc_data = 8'hB2;
        kbd_req  = 1'b1;
        rtc_req  = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rr_irq1: got %0b required 1", interrupt); end
        run_txn(1'b0, d, kg, rg, te);
        checks++; if (d !== 8'hA1 || kg !== 1'b1 || rg !== 1'b0) begin failures++; $display("FAIL rr_first_kbd: got d=%02h kg=%0b rg=%0b required A1 1 0", d, kg, rg); end
        step();
        run_txn(1'b0, d, kg, rg, te);
        checks++; if (d !== 8'hB2 || kg !== 1'b0 || rg !== 1'b1) begin failures++; $display("FAIL rr_second_rtc: got d=%02h kg=%0b rg=%0b required B2 0 1", d, kg, rg); end
        step();
        run_txn(1'b0, d, kg, rg, te);
        checks++; if (d !== 8'hA1 || kg !== 1'b1 || rg !== 1'b0) begin failures++; $display("FAIL rr_third_kbd: got d=%02h kg=%0b rg=%0b required A1 1 0", d, kg, rg); end
        kbd_req = 1'b0;
        rtc_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle: got %0b required 0", busy); end
    endtask

    task automatic test_src_read();
        rtc_data = 8'h50;
        rtc_req  = 1'b1;
        step();
        // The requester withdraws and its data changes. The held byte must stay the same.
        rtc_req  = 1'b0;
        rtc_data = 8'hFF;
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        port_id = 8'h03; read_strobe = 1'b1; #1;
        checks++; if (in_port !== 8'h01) begin failures++; $display("FAIL src_code: got %02h required 01", in_port); end
        step();
        checks++; if (busy !== 1'b1 || rtc_grant !== 1'b0) begin failures++; $display("FAIL src_read_stays: got busy=%0b rg=%0b required 1 0", busy, rtc_grant); end
        port_id = 8'h02; #1;
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL other_port: got %02h required 00", in_port); end
        step();
        checks++; if (busy !== 1'b1 || rtc_grant !== 1'b0) begin failures++; $display("FAIL other_read_stays: got busy=%0b rg=%0b required 1 0", busy, rtc_grant); end
        port_id = 8'h00; #1;
        checks++; if (in_port !== 8'h50) begin failures++; $display("FAIL src_data: got %02h required 50", in_port); end
        step();
        read_strobe = 1'b0;
        checks++; if (rtc_grant !== 1'b1 || kbd_grant !== 1'b0) begin failures++; $display("FAIL src_grant: got rg=%0b kg=%0b required 1 0", rtc_grant, kbd_grant); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL src_idle: got %0b required 0", busy); end
        $display("txn data=50 kbd_grant=0 rtc_grant=1 timeout_err=0");
    endtask

    task automatic test_timeout();
        int n;
        kbd_data = 8'h33;
        kbd_req  = 1'b1;
        // Data reads while in IRQ must be ignored.
        port_id     = 8'h00;
        read_strobe = 1'b1;
        step();
        n = (interrupt === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (interrupt !== 1'b1) break;
            n++;
        end
        read_strobe = 1'b0;
        checks++; if (n !== 16) begin failures++; $display("FAIL to_irq_len: got %0d required 16", n); end
        checks++; if (timeout_err !== 1'b1 || kbd_grant !== 1'b1 || rtc_grant !== 1'b0) begin failures++; $display("FAIL to_release: got te=%0b kg=%0b rg=%0b required 1 1 0", timeout_err, kbd_grant, rtc_grant); end
        kbd_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0 || kbd_grant !== 1'b0) begin failures++; $display("FAIL to_idle: got busy=%0b te=%0b kg=%0b required 0 0 0", busy, timeout_err, kbd_grant); end
        $display("txn data=33 kbd_grant=1 rtc_grant=0 timeout_err=1");
    endtask

    task automatic test_timeout_race();
        kbd_data = 8'h44;
        kbd_req  = 1'b1;
        step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        // The counter reads 1 in the first WAIT_READ cycle. After 14 more cycles it reads 15, the last cycle.
        for (int i = 0; i < 14; i++) step();
        checks++; if (busy !== 1'b1 || kbd_grant !== 1'b0) begin failures++; $display("FAIL race_waiting: got busy=%0b kg=%0b required 1 0", busy, kbd_grant); end
        port_id = 8'h00; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        checks++; if (kbd_grant !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL race_completion: got kg=%0b te=%0b required 1 0", kbd_grant, timeout_err); end
        kbd_req = 1'b0;
        step();
        $display("txn data=44 kbd_grant=1 rtc_grant=0 timeout_err=0");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic kg, rg, te;
        rtc_data = 8'h77;
        rtc_req  = 1'b1;
        step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || interrupt !== 1'b0 || {kbd_grant, rtc_grant, timeout_err} !== 3'b000) begin failures++; $display("FAIL mid_reset_outputs: got busy=%0b irq=%0b pulses=%03b required 0 0 000", busy, interrupt, {kbd_grant, rtc_grant, timeout_err}); end
        port_id = 8'h00; #1;
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL mid_reset_data: got %02h required 00", in_port); end
        reset = 1'b1;
        step();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL mid_reset_reserve: got %0b required 1", interrupt); end
        run_txn(1'b1, d, kg, rg, te);
        checks++; if (d !== 8'h77 || rg !== 1'b1 || kg !== 1'b0 || te !== 1'b0) begin failures++; $display("FAIL mid_reset_txn: got d=%02h rg=%0b kg=%0b te=%0b required 77 1 0 0", d, rg, kg, te); end
    endtask

    initial begin
        test_reset();
        test_kbd_basic();
        test_round_robin();
        test_src_read();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
